mmio_display_io: RTL and testbench

//  Parametrised memory-mapped board-I/O peripheral for the multi-cycle MIPS system; sits behind the data-memory decoder.

---
 rtl/mmio_display_io.sv | 194 +++++++++++++++++++
 tb/tb_mmio_display_io.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_display_io.sv
// Memory-mapped board I/O: synchronised switches, debounced buttons with W1C edge flags,
// and a scanned seven-segment display. Define MMIO_BTN_IRQ_EN to add IRQEN (0x14) and the irq output.
module mmio_display_io #(
    parameter int SW_W       = 16,
    parameter int NBTN       = 3,
    parameter int NDIGITS    = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sel,
    input  logic               we,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [SW_W-1:0]    sw,
    input  logic [NBTN-1:0]    btn,
    output logic [NDIGITS-1:0] AN,
    output logic [6:0]         A2G,
`ifdef MMIO_BTN_IRQ_EN
    output logic               DP,
    output logic               irq
`else
    output logic               DP
`endif
);

    localparam int DW    = $clog2(DEB_CYCLES);
    localparam int PW    = $clog2(SCAN_DIV);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [SW_W-1:0]      sw_s1, sw_s2;
    logic [NBTN-1:0]      btn_s1, btn_s2;
    logic [NBTN-1:0]      btn_lvl;
    logic [NBTN-1:0]      edge_q;
    logic [NBTN-1:0]      rise;
    logic [NBTN-1:0]      edge_clr;
    logic [DW-1:0]        deb_cnt [NBTN];

    logic [4*NDIGITS-1:0] disp;
    logic [NDIGITS-1:0]   en_mask;
    logic [NDIGITS-1:0]   dp_mask;
    logic [3:0]           nib [NDIGITS];

    logic [PW-1:0]        presc;
    logic [IDX_W-1:0]     idx;

    logic                 wr;
    logic                 unused_bits;

    assign wr          = sel & we;
    assign unused_bits = ^{addr[1:0], wdata};

    function automatic logic [6:0] seg7_n(input logic [3:0] h);
        // active-low {a,b,c,d,e,f,g}
        case (h)
            4'h0: seg7_n = 7'b0000001;
            4'h1: seg7_n = 7'b1001111;
            4'h2: seg7_n = 7'b0010010;
            4'h3: seg7_n = 7'b0000110;
            4'h4: seg7_n = 7'b1001100;
            4'h5: seg7_n = 7'b0100100;
            4'h6: seg7_n = 7'b0100000;
            4'h7: seg7_n = 7'b0001111;
            4'h8: seg7_n = 7'b0000000;
            4'h9: seg7_n = 7'b0000100;
            4'hA: seg7_n = 7'b0001000;
            4'hB: seg7_n = 7'b1100000;
            4'hC: seg7_n = 7'b0110001;
            4'hD: seg7_n = 7'b1000010;
            4'hE: seg7_n = 7'b0110000;
            default: seg7_n = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // A level change is accepted only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        rise = '0;
        for (int i = 0; i < NBTN; i++)
            rise[i] = btn_s2[i] & ~btn_lvl[i] & (deb_cnt[i] == DW'(DEB_CYCLES - 1));
    end

    assign edge_clr = (wr && addr[4:2] == 3'd2) ? wdata[NBTN-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_lvl <= '0;
            edge_q  <= '0;
            for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (btn_s2[i] == btn_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    btn_lvl[i] <= btn_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
            edge_q <= (edge_q & ~edge_clr) | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp    <= '0;
            en_mask <= '1;
            dp_mask <= '0;
        end else if (wr) begin
            case (addr[4:2])
                3'd3: disp <= wdata[4*NDIGITS-1:0];
                3'd4: begin
                    en_mask <= wdata[NDIGITS-1:0];
                    dp_mask <= wdata[8 +: NDIGITS];
                end
                default: ;
            endcase
        end
    end

`ifdef MMIO_BTN_IRQ_EN
    logic [NBTN-1:0] irqen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqen <= '0;
            irq   <= 1'b0;
        end else begin
            if (wr && addr[4:2] == 3'd5) irqen <= wdata[NBTN-1:0];
            irq <= |(edge_q & irqen);
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[4:2])
                3'd0: rdata = 32'(sw_s2);
                3'd1: rdata = 32'(btn_lvl);
                3'd2: rdata = 32'(edge_q);
                3'd3: rdata = 32'(disp);
                3'd4: rdata = {16'h0000, 8'(dp_mask), 8'(en_mask)};
`ifdef MMIO_BTN_IRQ_EN
                3'd5: rdata = 32'(irqen);
`endif
                default: rdata = '0;
            endcase
        end
    end

    for (genvar k = 0; k < NDIGITS; k++) begin : g_nib
        assign nib[k] = disp[4*k +: 4];
    end

    // Scan counters free-run; pins follow the index register one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
            AN    <= '1;
            A2G   <= 7'h7F;
            DP    <= 1'b1;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                if (idx == IDX_W'(NDIGITS - 1)) idx <= '0;
                else                             idx <= idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            AN  <= ~((NDIGITS'(1) << idx) & en_mask);
            A2G <= seg7_n(nib[idx]);
            DP  <= ~dp_mask[idx];
        end
    end

endmodule

// File: tb/tb_mmio_display_io.sv
// Directed self-checking bench for mmio_display_io with small scan/debounce parameters.
// Define MMIO_BTN_IRQ_EN for both files to exercise the irq path.
module tb_mmio_display_io;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, we;
    logic [4:0]  addr;
    logic [31:0] wdata, rdata;
    logic [15:0] sw;
    logic [2:0]  btn;
    logic [7:0]  AN;
    logic [6:0]  A2G;
    logic        DP;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_display_io #(
        .SW_W(16), .NBTN(3), .NDIGITS(8), .SCAN_DIV(4), .DEB_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .sw(sw), .btn(btn),
        .AN(AN), .A2G(A2G),
`ifdef MMIO_BTN_IRQ_EN
        .DP(DP), .irq(irq)
`else
        .DP(DP)
`endif
    );

`ifndef MMIO_BTN_IRQ_EN
    assign irq = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        check(tag, rdata, exp);
        sel = 1'b0;
    endtask

    logic [7:0] exp_an  [8];
    logic [6:0] exp_seg [8];
    logic       exp_dp  [8];
    logic       seen;
    int         n;

    initial begin
        exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_seg = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
        exp_dp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; sw = '0; btn = '0;
        #2;
        check("rst_an", 32'(AN), 32'hFF);
        check("rst_a2g", 32'(A2G), 32'h7F);
        check("rst_dp", 32'(DP), 32'h1);
        tick(2);
        reset = 1'b0;
        tick();
        check("first_an", 32'(AN), 32'hFE);
        check("first_a2g", 32'(A2G), 32'h01);
        rd(5'h10, 32'h0000_00FF, "ctrl_rst");

        sw = 16'hA5C3;
        tick(3);
        rd(5'h00, 32'h0000_A5C3, "sw_read");
        wr(5'h00, 32'h1234_5678);
        rd(5'h00, 32'h0000_A5C3, "sw_ro");
        rd(5'h14, 32'h0, "off14_rst");

        // short pulse is rejected
        btn = 3'b010;
        tick(5);
        btn = 3'b000;
        tick(20);
        rd(5'h04, 32'h0, "btn_glitch");
        rd(5'h08, 32'h0, "edge_glitch");

        btn = 3'b010;
        tick(8);
        rd(5'h04, 32'h0, "btn_not_yet");
        tick(12);
        rd(5'h04, 32'h2, "btn_held");
        rd(5'h08, 32'h2, "edge_held");

        btn = 3'b011;
        tick(20);
        rd(5'h08, 32'h3, "edge_011");
        rd(5'h08, 32'h3, "edge_noside");
        wr(5'h08, 32'h1);
        rd(5'h08, 32'h2, "w1c_bit0");

        btn = 3'b001;
        tick(20);
        rd(5'h04, 32'h1, "btn_fall");
        wr(5'h08, 32'h2);
        rd(5'h08, 32'h0, "w1c_bit1");

        // hold W1C of bit1 continuously while it rises again: set must win
        btn = 3'b011;
        sel = 1'b1; we = 1'b1; addr = 5'h08; wdata = 32'h2;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (rdata[1]) seen = 1'b1;
        end
        sel = 1'b0; we = 1'b0;
        check("set_beats_w1c", 32'(seen), 32'h1);
        tick();
        rd(5'h08, 32'h2, "edge_after_coinc");

        wr(5'h0C, 32'h7654_3210);
        wr(5'h10, 32'h0000_0F0F);
        rd(5'h0C, 32'h7654_3210, "disp_rb");
        rd(5'h10, 32'h0000_0F0F, "ctrl_rb");

        // align to the first cycle digit 0 is lit (digit 7 before it is dark)
        n = 0;
        while (!(AN == 8'hFE) && n < 100) begin tick(); n++; end
        while (AN == 8'hFE && n < 100) begin tick(); n++; end
        while (!(AN == 8'hFE) && n < 100) begin tick(); n++; end
        check("scan_sync", 32'(n < 100), 32'h1);
        for (int d = 0; d < 9; d++) begin
            check($sformatf("an_d%0d", d % 8), 32'(AN), 32'(exp_an[d % 8]));
            check($sformatf("seg_d%0d", d % 8), 32'(A2G), 32'(exp_seg[d % 8]));
            check($sformatf("dp_d%0d", d % 8), 32'(DP), 32'(exp_dp[d % 8]));
            tick(3);
            check($sformatf("hold_d%0d", d % 8), 32'(AN), 32'(exp_an[d % 8]));
            tick();
        end

        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_an", 32'(AN), 32'hFF);
        check("arst_a2g", 32'(A2G), 32'h7F);
        check("arst_dp", 32'(DP), 32'h1);
        check("arst_irq", 32'(irq), 32'h0);
        rd(5'h04, 32'h0, "arst_btn");
        rd(5'h08, 32'h0, "arst_edge");
        rd(5'h0C, 32'h0, "arst_disp");
        btn = 3'b000;
        tick(2);
        reset = 1'b0;
        tick();
        check("rel_an", 32'(AN), 32'hFE);
        check("rel_a2g", 32'(A2G), 32'h01);
        tick(20);

`ifdef MMIO_BTN_IRQ_EN
        wr(5'h14, 32'h4);
        rd(5'h14, 32'h4, "irqen_rb");
        btn = 3'b001;
        tick(20);
        rd(5'h08, 32'h1, "edge_b0");
        check("irq_b0_only", 32'(irq), 32'h0);
        btn = 3'b101;
        tick(20);
        check("irq_b2", 32'(irq), 32'h1);
        wr(5'h08, 32'h4);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);
        rd(5'h08, 32'h1, "edge_after_irq_clr");
`else
        wr(5'h14, 32'h4);
        rd(5'h14, 32'h0, "off14_ignored");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
